// File: rtl/jk_bank_driver.sv
// jk_bank_driver: command-side driver for a bank of W JK flip-flops.
// It turns LOAD/TOGGLE/CLEAR/SET commands into one cycle of J/K excitation,
// reads the bank back after FB_LAT cycles, retries on mismatch up to
// MAX_TRIES attempts, and returns the final q with an error flag.

`default_nettype none

module jk_bank_driver #(
    parameter int W         = 8,   // bank width in bits (1..32)
    parameter int FB_LAT    = 1,   // bank edge to q visible on q_fb (1..4)
    parameter int MAX_TRIES = 2    // DRIVE attempts per command (1..7)
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    input  logic [W-1:0] q_fb,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_err,
    output logic [W-1:0] rsp_q,
    output logic [2:0]   rsp_tries
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_SET    = 2'b11;

    localparam logic [2:0] LP_FB_LAT    = 3'(FB_LAT);
    localparam logic [2:0] LP_MAX_TRIES = 3'(MAX_TRIES);

    // Registered state
    state_t       r_state;
    logic [W-1:0] r_j;
    logic [W-1:0] r_k;
    logic [W-1:0] r_exp;
    logic [2:0]   r_tries;
    logic [2:0]   r_wait;
    logic         r_rsp_err;
    logic [W-1:0] r_rsp_q;
    logic [2:0]   r_rsp_tries;

    // Next-state values
    state_t       w_state_nxt;
    logic [W-1:0] w_j_nxt;
    logic [W-1:0] w_k_nxt;
    logic [W-1:0] w_exp_nxt;
    logic [2:0]   w_tries_nxt;
    logic [2:0]   w_wait_nxt;
    logic         w_rsp_err_nxt;
    logic [W-1:0] w_rsp_q_nxt;
    logic [2:0]   w_rsp_tries_nxt;

    logic [W-1:0] w_cmd_exp;
    logic         w_match;

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign j         = r_j;
    assign k         = r_k;
    assign rsp_err   = r_rsp_err;
    assign rsp_q     = r_rsp_q;
    assign rsp_tries = r_rsp_tries;

    // Target bank value for the offered command, relative to the current q
    always_comb begin
        unique case (cmd_op)
            OP_LOAD:   w_cmd_exp = cmd_data;
            OP_TOGGLE: w_cmd_exp = q_fb ^ cmd_data;
            OP_CLEAR:  w_cmd_exp = '0;
            OP_SET:    w_cmd_exp = q_fb | cmd_data;
            default:   w_cmd_exp = '0;
        endcase
    end

    assign w_match = (q_fb == r_exp);

    // Next-state and next-register logic for the command sequencer
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        w_state_nxt     = r_state;
        w_j_nxt         = '0;
        w_k_nxt         = '0;
        w_exp_nxt       = r_exp;
        w_tries_nxt     = r_tries;
        w_wait_nxt      = r_wait;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_q_nxt     = r_rsp_q;
        w_rsp_tries_nxt = r_rsp_tries;

        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    // Set only bits that must rise, reset only bits that must
                    // fall: j&k can never both be 1 for the same bit.
                    w_exp_nxt   = w_cmd_exp;
                    w_j_nxt     = w_cmd_exp & ~q_fb;
                    w_k_nxt     = ~w_cmd_exp & q_fb;
                    w_tries_nxt = 3'd1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // Excitation is seen by the bank at this closing edge only.
                w_wait_nxt  = LP_FB_LAT;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_wait_nxt = r_wait - 3'd1;
                if (r_wait == 3'd1) begin
                    w_rsp_q_nxt     = q_fb;
                    w_rsp_tries_nxt = r_tries;
                    if (w_match) begin
                        w_rsp_err_nxt = 1'b0;
                        w_state_nxt   = S_RESP;
                    end else if (r_tries < LP_MAX_TRIES) begin
                        w_j_nxt     = r_exp & ~q_fb;
                        w_k_nxt     = ~r_exp & q_fb;
                        w_tries_nxt = r_tries + 3'd1;
                        w_state_nxt = S_DRIVE;
                    end else begin
                        w_rsp_err_nxt = 1'b1;
                        w_state_nxt   = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; clrn is not in the sensitivity list.
        if (!clrn) begin
            r_state     <= S_IDLE;
            r_j         <= '0;
            r_k         <= '0;
            r_exp       <= '0;
            r_tries     <= '0;
            r_wait      <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_q     <= '0;
            r_rsp_tries <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            r_state     <= w_state_nxt;
            r_j         <= w_j_nxt;
            r_k         <= w_k_nxt;
            r_exp       <= w_exp_nxt;
            r_tries     <= w_tries_nxt;
            r_wait      <= w_wait_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_q     <= w_rsp_q_nxt;
            r_rsp_tries <= w_rsp_tries_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
// Testbench for jk_bank_driver: models an 8-bit JK bank with 1-cycle
// readback and optional bit-7 faults, issues directed commands, and checks
// responses through a scoreboard queue drained by a monitor process.

`timescale 1ns/1ps

module tb_jk_bank_driver;

    localparam int W = 8;

    typedef struct {
        logic [7:0] q;
        logic       err;
        logic [2:0] tries;
    } rsp_t;

    logic         clk = 1'b0;
    logic         clrn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q_fb;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_err;
    logic [W-1:0] rsp_q;
    logic [2:0]   rsp_tries;

    // Bank model and fault controls
    logic [W-1:0] bank_q = '0;
    logic [W-1:0] bank_nq;
    int           ign_req = 0;
    int           ign_done = 0;
    bit           stuck_perm = 1'b0;

    rsp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    jk_bank_driver #(.W(W), .FB_LAT(1), .MAX_TRIES(2)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_err   (rsp_err),
        .rsp_q     (rsp_q),
        .rsp_tries (rsp_tries)
    );

    always #5 clk = ~clk;

    // Readback is the bank register itself: an update at one edge is seen at the next
    assign q_fb = bank_q;

    // JK bank: q <= j&~q | ~k&q, with optional one-shot or permanent bit-7 fault
    always @(posedge clk) begin
        bank_nq = (j & ~bank_q) | (~k & bank_q);
        if (stuck_perm) begin
            bank_nq[7] = bank_q[7];
        end else if ((ign_req != ign_done) && (j[7] || k[7])) begin
            bank_nq[7] = bank_q[7];
            ign_done <= ign_done + 1;
        end
        bank_q <= bank_nq;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: excitation exclusivity every cycle, responses popped at handshake
    always @(negedge clk) begin
        rsp_t e;
        check("j_k_exclusive", 32'(j & k), 32'h0);
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rsp_q=0x%0h with no command pending", rsp_q);
            end else begin
                e = sb.pop_front();
                check("rsp_q", 32'(rsp_q), 32'(e.q));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_tries", 32'(rsp_tries), 32'(e.tries));
            end
        end
    end

    // Offer one command, check its first excitation and, optionally, the retry excitation
    task automatic send(input logic [1:0] op, input logic [7:0] data,
                        input logic [7:0] ej, input logic [7:0] ek,
                        input bit expect_rsp, input logic [7:0] eq,
                        input logic eerr, input logic [2:0] etries,
                        input bit retry, input logic [7:0] rj);
        int n;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: cmd_ready=0 after %0d cycles, expected 1", n);
            cmd_valid = 1'b0;
            return;
        end
        if (expect_rsp) sb.push_back('{q: eq, err: eerr, tries: etries});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 8'($urandom);
        @(negedge clk);
        check("drive_j", 32'(j), 32'(ej));
        check("drive_k", 32'(k), 32'(ek));
        if (retry) begin
            @(negedge clk);
            check("wait_j", 32'(j), 32'h0);
            @(negedge clk);
            check("retry_j", 32'(j), 32'(rj));
            check("retry_k", 32'(k), 32'h0);
        end
    endtask

    // Wait (bounded) until every expected response has been consumed
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        int n;
        int saw;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_j", 32'(j), 32'h0);
        check("rst_k", 32'(k), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_rsp_q", 32'(rsp_q), 32'h0);
        check("rst_rsp_tries", 32'(rsp_tries), 32'h0);
        @(posedge clk);
        #1;
        clrn = 1'b1;

        // LOAD 0xA5 from 0x00, with first-try latency check
        send(2'b00, 8'hA5, 8'hA5, 8'h00, 1, 8'hA5, 1'b0, 3'd1, 0, 8'h00);
        check("lat_drive_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("lat_wait_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("lat_resp_valid", 32'(rsp_valid), 32'h1);

        // TOGGLE 0x0F from 0xA5, CLEAR from 0xAA
        send(2'b01, 8'h0F, 8'h0A, 8'h05, 1, 8'hAA, 1'b0, 3'd1, 0, 8'h00);
        send(2'b10, 8'h5C, 8'h00, 8'hAA, 1, 8'h00, 1'b0, 3'd1, 0, 8'h00);

        // Reach 0x30, SET 0x03, then a zero-change LOAD 0x33, then CLEAR
        send(2'b00, 8'h30, 8'h30, 8'h00, 1, 8'h30, 1'b0, 3'd1, 0, 8'h00);
        send(2'b11, 8'h03, 8'h03, 8'h00, 1, 8'h33, 1'b0, 3'd1, 0, 8'h00);
        send(2'b00, 8'h33, 8'h00, 8'h00, 1, 8'h33, 1'b0, 3'd1, 0, 8'h00);
        send(2'b10, 8'h00, 8'h00, 8'h33, 1, 8'h00, 1'b0, 3'd1, 0, 8'h00);
        drain();

        // Bit 7 ignored once: retry succeeds on the second attempt
        ign_req++;
        send(2'b00, 8'h80, 8'h80, 8'h00, 1, 8'h80, 1'b0, 3'd2, 1, 8'h80);
        send(2'b10, 8'h00, 8'h00, 8'h80, 1, 8'h00, 1'b0, 3'd1, 0, 8'h00);
        drain();

        // Bit 7 stuck permanently: both attempts fail
        stuck_perm = 1'b1;
        send(2'b00, 8'h80, 8'h80, 8'h00, 1, 8'h00, 1'b1, 3'd2, 1, 8'h80);
        drain();
        stuck_perm = 1'b0;

        // Response back-pressure: outputs stable, no new command, bank held
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send(2'b00, 8'h5A, 8'h5A, 8'h00, 1, 8'h5A, 1'b0, 3'd1, 0, 8'h00);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 32'(rsp_valid), 32'h1);
            check("hold_rsp_q", 32'(rsp_q), 32'h5A);
            check("hold_rsp_tries", 32'(rsp_tries), 32'h1);
            check("hold_cmd_ready", 32'(cmd_ready), 32'h0);
            check("hold_jk", 32'({j, k}), 32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_cmd_ready", 32'(cmd_ready), 32'h1);
        check("release_rsp_valid", 32'(rsp_valid), 32'h0);
        drain();

        // Reset during DRIVE of LOAD 0xFF: command abandoned, no response
        send(2'b00, 8'hFF, 8'hA5, 8'h00, 0, 8'h00, 1'b0, 3'd0, 0, 8'h00);
        clrn = 1'b0;
        @(negedge clk);
        check("abort_j", 32'(j), 32'h0);
        check("abort_k", 32'(k), 32'h0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        @(negedge clk);
        check("abort_cmd_ready", 32'(cmd_ready), 32'h1);
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) saw++;
        end
        check("abort_no_rsp", 32'(saw), 32'h0);

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
